// File: rtl/alu_pkg.sv
// Shared op-vector/instruction-field code table for the ALU op encoder and its
// matching decoder. Index i of OP_TABLE is the op vector {op0..op4} for field i.
package alu_pkg;

    localparam int OPS_W  = 5;
    localparam int CODE_W = 3;

    localparam logic [7:0][OPS_W-1:0] OP_TABLE = {
        5'b00100,   // 7
        5'b11110,   // 6
        5'b01101,   // 5
        5'b10000,   // 4
        5'b10100,   // 3
        5'b01000,   // 2
        5'b11101,   // 1
        5'b00000    // 0
    };

    typedef struct packed {
        logic              legal;
        logic [CODE_W-1:0] code;
    } enc_t;

    function automatic enc_t encode_ops(input logic [OPS_W-1:0] ops);
        enc_t r;
        r.legal = 1'b0;
        r.code  = '0;
        for (int i = 0; i < 8; i++) begin
            if (OP_TABLE[i] == ops) begin
                r.legal = 1'b1;
                r.code  = CODE_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [OPS_W-1:0] decode_code(input logic [CODE_W-1:0] code);
        return OP_TABLE[code];
    endfunction

endpackage

// File: rtl/alu_enc_fifo.sv
// Small circular FIFO; full/empty come from an occupancy counter, not pointer compare.
module alu_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (occ_q == OCC_W'(DEPTH));
    assign empty   = (occ_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_select.sv
// Decoder from a 3-bit instruction field back to its op vector {op0..op4}.
module alu_select
    import alu_pkg::*;
(
    input  logic [2:0] code,
    output logic [4:0] ops
);

    assign ops = decode_code(code);

endmodule

// File: rtl/alu_op_encoder.sv
// Encodes 5-bit ALU control vectors into 3-bit instruction fields through a
// small FIFO; illegal vectors are consumed, flagged and counted, never queued.
module alu_op_encoder
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_ops,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_i3,
    output logic             out_i4,
    output logic             out_i5,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [15:0]      issued_cnt
);

    enc_t             enc;
    logic             in_hs, out_hs, push;
    logic             fifo_full, fifo_empty;
    logic [2:0]       head;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic [15:0]      issued_cnt_q, issued_cnt_d;

    assign enc       = encode_ops(in_ops);
    assign in_ready  = !fifo_full;
    assign in_hs     = in_valid && in_ready;
    assign push      = in_hs && enc.legal;
    assign out_valid = !fifo_empty;
    assign out_hs    = out_valid && out_ready;

    alu_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (enc.code),
        .pop   (out_hs),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {out_i3, out_i4, out_i5} = out_valid ? head : 3'b000;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;
    assign issued_cnt  = issued_cnt_q;

    always_comb begin
        illegal_d     = in_hs && !enc.legal;
        illegal_cnt_d = illegal_cnt_q;
        issued_cnt_d  = issued_cnt_q;
        if (illegal_d && (illegal_cnt_q != '1)) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
        if (out_hs) begin
            issued_cnt_d = issued_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
            issued_cnt_q  <= '0;
        end else begin
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
            issued_cnt_q  <= issued_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_op_encoder.sv
// Bench for alu_op_encoder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a decoder loopback.
module tb_alu_op_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_ops;
    logic             out_valid;
    logic             out_ready;
    logic             out_i3, out_i4, out_i5;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;
    logic [15:0]      issued_cnt;
    logic [2:0]       out_code;
    logic [4:0]       sel_ops;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ops      (in_ops),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_i3      (out_i3),
        .out_i4      (out_i4),
        .out_i5      (out_i5),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt),
        .issued_cnt  (issued_cnt)
    );

    assign out_code = {out_i3, out_i4, out_i5};

    alu_select u_sel (.code(out_code), .ops(sel_ops));

    // Op vectors in instruction-field order 0..7, straight from the encoding table.
    logic [4:0] legal_tab [8] = '{5'b00000, 5'b11101, 5'b01000, 5'b10100,
                                  5'b10000, 5'b01101, 5'b11110, 5'b00100};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void spec_encode(input logic [4:0] ops, output logic lg, output logic [2:0] c);
        lg = 1'b1;
        case (ops)
            5'b00000: c = 3'd0;
            5'b11101: c = 3'd1;
            5'b01000: c = 3'd2;
            5'b10100: c = 3'd3;
            5'b10000: c = 3'd4;
            5'b01101: c = 3'd5;
            5'b11110: c = 3'd6;
            5'b00100: c = 3'd7;
            default: begin c = 3'd0; lg = 1'b0; end
        endcase
    endfunction

    // Reference model: queue of codes, pending illegal flag, two counters.
    logic [2:0]  m_q [$];
    logic [4:0]  lb_q [$];
    logic        m_ill;
    logic [7:0]  m_icnt;
    logic [15:0] m_iss;
    logic        model_ok = 1'b0;

    always @(posedge clk) begin
        int         sz;
        logic       lg;
        logic [2:0] c;
        if (!rst_n) begin
            m_q.delete();
            lb_q.delete();
            m_ill    = 1'b0;
            m_icnt   = 8'd0;
            m_iss    = 16'd0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            sz    = m_q.size();
            m_ill = 1'b0;
            lg    = 1'b0;
            c     = 3'd0;
            if (in_valid && sz < DEPTH) begin
                spec_encode(in_ops, lg, c);
                if (!lg) begin
                    m_ill = 1'b1;
                    if (m_icnt != 8'hFF) m_icnt = m_icnt + 8'd1;
                end
            end
            if (sz > 0 && out_ready) begin
                void'(m_q.pop_front());
                m_iss = m_iss + 16'd1;
            end
            if (in_valid && sz < DEPTH && lg) begin
                m_q.push_back(c);
                lb_q.push_back(in_ops);
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok && rst_n) begin
            check("in_ready", in_ready, m_q.size() < DEPTH);
            check("out_valid", out_valid, m_q.size() > 0);
            if (m_q.size() > 0) check("out_code", out_code, m_q[0]);
            else                check("out_code_idle", out_code, 3'b000);
            check("illegal", illegal, m_ill);
            check("illegal_cnt", illegal_cnt, m_icnt);
            check("issued_cnt", issued_cnt, m_iss);
            if (out_valid && out_ready) begin
                if (lb_q.size() == 0) begin
                    check("loopback_underflow", 1, 0);
                end else begin
                    check("loopback_ops", sel_ops, lb_q[0]);
                    void'(lb_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] ops, input logic ordy);
        in_valid  = v;
        in_ops    = ops;
        out_ready = ordy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'b00000, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_code", out_code, 3'b000);
        check("rst_illegal_cnt", illegal_cnt, 0);
        check("rst_issued_cnt", issued_cnt, 0);

        // All eight legal vectors, each visible one cycle after its push.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, legal_tab[i], 1'b1);
            cyc();
            check("enc_valid", out_valid, 1);
            check("enc_code", out_code, i);
            drive(1'b0, 5'b00000, 1'b1);
            cyc();
        end
        check("enc_issued", issued_cnt, 8);
        check("enc_illegal_cnt", illegal_cnt, 0);

        drive(1'b1, 5'b11111, 1'b1);
        cyc();
        check("ill_pulse_a", illegal, 1);
        check("ill_no_valid_a", out_valid, 0);
        drive(1'b1, 5'b00001, 1'b1);
        cyc();
        check("ill_pulse_b", illegal, 1);
        check("ill_cnt_2", illegal_cnt, 2);
        check("ill_no_valid_b", out_valid, 0);
        drive(1'b0, 5'b00000, 1'b1);
        cyc();
        check("ill_pulse_end", illegal, 0);

        // Backpressure: fill both entries, hold, then release.
        drive(1'b1, 5'b11101, 1'b0);
        cyc();
        check("bp_code_a", out_code, 3'b001);
        check("bp_ready_a", in_ready, 1);
        drive(1'b1, 5'b01000, 1'b0);
        cyc();
        check("bp_full", in_ready, 0);
        check("bp_hold_a", out_code, 3'b001);
        drive(1'b1, 5'b10000, 1'b0);
        cyc();
        check("bp_still_full", in_ready, 0);
        check("bp_hold_b", out_code, 3'b001);
        drive(1'b1, 5'b10000, 1'b1);
        cyc();
        check("bp_rel_code", out_code, 3'b010);
        check("bp_rel_ready", in_ready, 1);
        cyc();
        check("bp_third", out_code, 3'b100);
        drive(1'b0, 5'b00000, 1'b1);
        cyc();
        check("bp_drained", out_valid, 0);
        check("bp_issued", issued_cnt, 11);

        // Reset with two entries queued and handshakes pending.
        drive(1'b1, 5'b01101, 1'b0);
        cyc();
        drive(1'b1, 5'b11110, 1'b0);
        cyc();
        check("mid_full", in_ready, 0);
        rst_n = 1'b0;
        drive(1'b1, 5'b11111, 1'b1);
        cyc();
        rst_n = 1'b1;
        drive(1'b0, 5'b00000, 1'b0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_code", out_code, 3'b000);
        check("mid_rst_illegal", illegal, 0);
        check("mid_rst_icnt", illegal_cnt, 0);
        check("mid_rst_issued", issued_cnt, 0);
        cyc();
        check("mid_rst_stays_empty", out_valid, 0);

        // Saturation of illegal_cnt.
        drive(1'b1, 5'b11111, 1'b0);
        for (int i = 0; i < 255; i++) cyc();
        check("sat_255", illegal_cnt, 255);
        cyc();
        check("sat_hold", illegal_cnt, 255);
        check("sat_pulse", illegal, 1);

        // Wrap of issued_cnt: 65535 handshakes then one more.
        drive(1'b1, 5'b10100, 1'b1);
        for (int i = 0; i < 65535; i++) cyc();
        drive(1'b0, 5'b00000, 1'b1);
        cyc();
        check("wrap_ffff", issued_cnt, 16'hFFFF);
        drive(1'b1, 5'b00100, 1'b1);
        cyc();
        check("wrap_last_code", out_code, 3'b111);
        drive(1'b0, 5'b00000, 1'b1);
        cyc();
        check("wrap_zero", issued_cnt, 16'h0000);
        check("wrap_empty", out_valid, 0);

        // Random legal traffic looped back through the decoder.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), legal_tab[$urandom_range(0, 7)],
                  1'($urandom_range(0, 1)));
            cyc();
        end
        drive(1'b0, 5'b00000, 1'b1);
        for (int i = 0; i < 4; i++) cyc();
        check("lb_drained", lb_q.size(), 0);
        check("lb_out_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_encoder.md
ALU_OP_ENCODER -- requirements
Module: alu_op_encoder

Interface
REQ-001 Parameter: DEPTH, default 2, FIFO entry count; legal values 2 or 4.
REQ-002 Parameter: CNT_W, default 8, width of illegal_cnt.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port: in_valid  input  1  producer presents a control vector.
REQ-006 Port: in_ready  output  1  block accepts in_ops this cycle.
REQ-007 Port: in_ops  input  5  control vector; in_ops[4]=op0 ... in_ops[0]=op4.
REQ-008 Port: out_valid  output  1  encoded instruction field valid.
REQ-009 Port: out_ready  input  1  consumer takes the field this cycle.
REQ-010 Port: out_i3, out_i4, out_i5  output  1 each  encoded instruction bits.
REQ-011 Port: illegal  output  1  one-cycle pulse, illegal vector was consumed.
REQ-012 Port: illegal_cnt  output  CNT_W  saturating count of illegal vectors.
REQ-013 Port: issued_cnt  output  16  wrapping count of output handshakes.

Function
REQ-014 Encoding {op0..op4} -> {i3,i4,i5} SHALL be: 00000->000, 11101->001, 01000->010, 10100->011, 10000->100, 01101->101, 11110->110, 00100->111.
REQ-015 Any other vector SHALL be illegal.
REQ-016 Input handshake SHALL occur when in_valid and in_ready are both high on a rising edge.
REQ-017 Output handshake SHALL occur when out_valid and out_ready are both high on a rising edge.
REQ-018 in_ready SHALL equal "FIFO not full", registered-state only; a pop in the same cycle SHALL NOT raise in_ready (no full-bypass).
REQ-019 A legal accepted vector SHALL be encoded and pushed into the FIFO in the same edge.
REQ-020 An illegal accepted vector SHALL be consumed but not enqueued.
REQ-021 illegal SHALL be high in the cycle after an illegal handshake, otherwise low.
REQ-022 illegal_cnt SHALL increment by 1 per illegal handshake and hold at 2^CNT_W-1.
REQ-023 out_valid SHALL equal "FIFO not empty"; out_i3..out_i5 SHALL show the head entry, registered, with no combinational path from in_* to out_*.
REQ-024 Latency: a legal push into an empty FIFO at edge N SHALL give out_valid=1 from edge N onward (visible in cycle N+1).
REQ-025 When out_valid is high and out_ready low, out_i3..out_i5 SHALL stay stable until the handshake.
REQ-026 When not full and not empty, a simultaneous push and pop SHALL keep the occupancy unchanged and preserve order.
REQ-027 When out_valid=0, out_i3..out_i5 SHALL read 000.
REQ-028 issued_cnt SHALL increment per output handshake and wrap from 0xFFFF to 0x0000.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH, with full/empty decided by an occupancy counter of width clog2(DEPTH)+1.

Reset
REQ-030 While rst_n=0 at a rising edge, the FIFO SHALL empty, with out_valid=0, outputs 000, in_ready=1 in the following cycle, illegal=0, illegal_cnt=0, issued_cnt=0.
REQ-031 Reset mid-operation SHALL discard all queued entries, and any handshake in the reset cycle SHALL be ignored.

Structure
REQ-032 The eight legal code pairs SHALL be constants in shared package alu_pkg, which alu_select also uses.
REQ-033 Storage SHALL be a sub-module alu_enc_fifo (DEPTH, width 3) with push/pop/full/empty.

Verification
REQ-034 Reset, then each of the 8 legal vectors with out_ready=1 -> the matching i-field per REQ-014 one cycle later, issued_cnt=8, illegal_cnt=0.
REQ-035 Vectors 11111 and 00001 -> illegal pulses twice, illegal_cnt=2, out_valid stays 0.
REQ-036 out_ready=0 with legal pushes 11101, 01000, 10000 at DEPTH=2 -> in_ready=0 after two pushes, out field holds 001; release -> 001, 010, then 100 accepted and out.
REQ-037 illegal_cnt at 255 plus one more illegal -> stays 255; issued_cnt at 0xFFFF plus one pop -> 0x0000.
REQ-038 rst_n=0 with 2 entries queued -> next cycle out_valid=0, in_ready=1, all counters 0.
REQ-039 Loopback into alu_select with random legal traffic and random out_ready -> decoded ops equal the pushed vectors, in order.
